// File: rtl/dv_apb_mem_slave.sv
// dv_apb_mem_slave: APB completer memory model with byte-strobed storage, wait-state generation, error window and transfer counters
// Ports: clk, reset_n (async active-low); APB completer inputs psel/penable/paddr/pwrite/pwdata/pstrb;
//        responses prdata/pready/pslverr; proto_err one-cycle violation pulse; xfer_cnt/err_cnt completed and erroring transfers.
module dv_apb_mem_slave #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int DEPTH = 256,
  parameter int SEL_W = 2,
  parameter int SEL_IDX = 0,
  parameter int WAIT_MODE = 0,
  parameter logic [3:0] WAIT_CYC = 4'd2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [ADDR_W-1:0] ERR_BASE = '0,
  parameter logic [ADDR_W-1:0] ERR_LIMIT = '0,
  parameter logic [15:0] RESET_DATA = 16'hABCD
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                penable,
  input  logic [SEL_W-1:0]    psel,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic                pwrite,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                proto_err,
  output logic [15:0]         xfer_cnt,
  output logic [15:0]         err_cnt
);
  localparam int BW = DATA_W / 8;
  localparam int OFS = $clog2(BW);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] RST_WORD = DATA_W'(RESET_DATA);
  localparam bit WIN_EN = ERR_LIMIT >= ERR_BASE;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic sel, in_err, setup, done, abort, bad_en;
  logic [ADDR_W-1:0] idx;
  logic [3:0] wait_n, cnt;
  logic [15:0] lfsr;
  logic [IW-1:0] a_idx;
  logic a_err, a_write;
  logic [DATA_W-1:0] a_wdata, bmask, merged;
  logic [DATA_W-1:0] mem [DEPTH];
  logic unused_psel;
  assign unused_psel = ^psel;
  assign sel = psel[SEL_IDX];
  assign idx = paddr >> OFS;
  // Window test as an unsigned offset compare; only meaningful when the window is enabled.
  assign in_err = (|(idx >> IW)) || (WIN_EN && (paddr - ERR_BASE) <= (ERR_LIMIT - ERR_BASE));
  assign wait_n = WAIT_MODE == 1 ? WAIT_CYC : WAIT_MODE == 2 ? (lfsr[3:0] & WAIT_CYC) : 4'd0;
  for (genvar g = 0; g < BW; g++) begin : g_lane
    assign bmask[8*g +: 8] = {8{pstrb[g]}};
  end
  assign merged = (mem[a_idx] & ~bmask) | (a_wdata & bmask);
  always_comb begin
    state_nx = state;
    setup = 1'b0;
    done = 1'b0;
    abort = 1'b0;
    bad_en = 1'b0;
    if (state == IDLE) begin
      setup = sel && !penable;
      bad_en = sel && penable;
      state_nx = setup ? ACCESS : IDLE;
    end else begin
      done = sel && penable && pready;
      abort = !sel;
      state_nx = (done || abort) ? IDLE : ACCESS;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
      cnt <= 4'd0;
      a_idx <= '0;
      a_err <= 1'b0;
      a_write <= 1'b0;
      a_wdata <= '0;
      prdata <= RST_WORD;
      pready <= 1'b0;
      pslverr <= 1'b0;
      proto_err <= 1'b0;
      xfer_cnt <= 16'd0;
      err_cnt <= 16'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      proto_err <= bad_en || abort;
      if (setup) begin
        cnt <= wait_n;
        a_idx <= idx[IW-1:0];
        a_err <= in_err;
        a_write <= pwrite;
        a_wdata <= pwdata;
        pready <= wait_n == 4'd0;
        pslverr <= wait_n == 4'd0 && in_err;
        if (wait_n == 4'd0 && !pwrite) prdata <= in_err ? '0 : mem[idx[IW-1:0]];
      end else if (done || abort) begin
        cnt <= 4'd0;
        pready <= 1'b0;
        pslverr <= 1'b0;
        if (done) begin
          xfer_cnt <= xfer_cnt + 16'd1;
          err_cnt <= err_cnt + 16'(pslverr);
        end
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
        // Last wait cycle: response becomes visible together with pready.
        if (cnt == 4'd1) begin
          pready <= 1'b1;
          pslverr <= a_err;
          if (!a_write) prdata <= a_err ? '0 : mem[a_idx];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem <= '{default: RST_WORD};
    else if (done && a_write && !a_err) mem[a_idx] <= merged;
  end
endmodule

// File: tb/tb_dv_apb_mem_slave.sv
// tb_dv_apb_mem_slave: directed bench for dv_apb_mem_slave in no-wait, fixed-wait and random-wait configurations
module tb_dv_apb_mem_slave;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic penable = 1'b0;
  logic pwrite = 1'b0;
  logic [2:0] sel_vec = 3'b000;
  logic [19:0] paddr = '0;
  logic [15:0] pwdata = '0;
  logic [1:0] pstrb = '0;
  logic [15:0] prdata [3];
  logic pready [3];
  logic pslverr [3];
  logic proto_err [3];
  logic [15:0] xfer_cnt [3];
  logic [15:0] err_cnt [3];
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  dv_apb_mem_slave #(.DEPTH(1024), .ERR_BASE(20'h100), .ERR_LIMIT(20'h1FF)) u0 (
    .clk(clk), .reset_n(reset_n), .penable(penable), .psel(sel_vec[1:0]), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .pstrb(pstrb), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .proto_err(proto_err[0]), .xfer_cnt(xfer_cnt[0]), .err_cnt(err_cnt[0]));
  dv_apb_mem_slave #(.SEL_IDX(1), .WAIT_MODE(1), .WAIT_CYC(4'd3), .ERR_BASE(20'h1), .ERR_LIMIT(20'h0)) u1 (
    .clk(clk), .reset_n(reset_n), .penable(penable), .psel(sel_vec[1:0]), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .pstrb(pstrb), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .proto_err(proto_err[1]), .xfer_cnt(xfer_cnt[1]), .err_cnt(err_cnt[1]));
  dv_apb_mem_slave #(.SEL_IDX(1), .WAIT_MODE(2), .WAIT_CYC(4'd3), .ERR_BASE(20'h1), .ERR_LIMIT(20'h0)) u2 (
    .clk(clk), .reset_n(reset_n), .penable(penable), .psel(sel_vec[2:1]), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .pstrb(pstrb), .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]),
    .proto_err(proto_err[2]), .xfer_cnt(xfer_cnt[2]), .err_cnt(err_cnt[2]));
  task automatic xfer(input int d, input logic w, input logic [19:0] a, input logic [15:0] wd, input logic [1:0] s,
                      output logic [15:0] rd, output logic er, output int waits);
    sel_vec = 3'(1 << d);
    paddr = a;
    pwrite = w;
    pwdata = wd;
    pstrb = s;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    rd = prdata[d];
    er = pslverr[d];
    vecs++; if (pready[d] !== 1'b1) begin errs++; $display("FAIL timeout u%0d addr %h: pready still %b after %0d cycles", d, a, pready[d], waits); end
    @(posedge clk); #1;
    sel_vec = 3'b000;
    penable = 1'b0;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    vecs++; if (prdata[0] !== 16'hABCD) begin errs++; $display("FAIL rst_prdata: got %h want abcd", prdata[0]); end
    vecs++; if (pready[0] !== 1'b0) begin errs++; $display("FAIL rst_pready: got %b want 0", pready[0]); end
    vecs++; if (pslverr[0] !== 1'b0) begin errs++; $display("FAIL rst_pslverr: got %b want 0", pslverr[0]); end
    vecs++; if (proto_err[0] !== 1'b0) begin errs++; $display("FAIL rst_proto_err: got %b want 0", proto_err[0]); end
    vecs++; if (xfer_cnt[0] !== 16'd0) begin errs++; $display("FAIL rst_xfer_cnt: got %0d want 0", xfer_cnt[0]); end
    vecs++; if (err_cnt[0] !== 16'd0) begin errs++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt[0]); end
    vecs++; if (prdata[1] !== 16'hABCD) begin errs++; $display("FAIL rst_prdata_u1: got %h want abcd", prdata[1]); end
  endtask
  task automatic test_mode0;
    logic [15:0] rd;
    logic er;
    int wt;
    xfer(0, 1'b1, 20'h10, 16'h1234, 2'b11, rd, er, wt);
    vecs++; if (wt != 0) begin errs++; $display("FAIL m0_wr_wait: got %0d want 0", wt); end
    vecs++; if (er !== 1'b0) begin errs++; $display("FAIL m0_wr_err: got %b want 0", er); end
    xfer(0, 1'b0, 20'h10, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (wt != 0) begin errs++; $display("FAIL m0_rd_wait: got %0d want 0", wt); end
    vecs++; if (rd !== 16'h1234) begin errs++; $display("FAIL m0_rd_data: got %h want 1234", rd); end
    vecs++; if (er !== 1'b0) begin errs++; $display("FAIL m0_rd_err: got %b want 0", er); end
    vecs++; if (xfer_cnt[0] !== 16'd2) begin errs++; $display("FAIL m0_xfer_cnt: got %0d want 2", xfer_cnt[0]); end
  endtask
  task automatic test_strobe;
    logic [15:0] rd;
    logic er;
    int wt;
    xfer(0, 1'b1, 20'h30, 16'h55AA, 2'b01, rd, er, wt);
    xfer(0, 1'b0, 20'h30, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'hABAA) begin errs++; $display("FAIL strb_lo: got %h want abaa", rd); end
    xfer(0, 1'b1, 20'h30, 16'hFFFF, 2'b00, rd, er, wt);
    vecs++; if (er !== 1'b0) begin errs++; $display("FAIL strb_none_err: got %b want 0", er); end
    xfer(0, 1'b0, 20'h30, 16'h0000, 2'b00, rd, er, wt);
    vecs++; if (rd !== 16'hABAA) begin errs++; $display("FAIL strb_none: got %h want abaa", rd); end
    xfer(0, 1'b1, 20'h32, 16'h1234, 2'b10, rd, er, wt);
    xfer(0, 1'b0, 20'h32, 16'h0000, 2'b01, rd, er, wt);
    vecs++; if (rd !== 16'h12CD) begin errs++; $display("FAIL strb_hi: got %h want 12cd", rd); end
  endtask
  task automatic test_hold;
    logic [15:0] rd;
    logic er;
    int wt;
    xfer(0, 1'b0, 20'h10, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'h1234) begin errs++; $display("FAIL hold_rd: got %h want 1234", rd); end
    xfer(0, 1'b1, 20'h10, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'h1234) begin errs++; $display("FAIL hold_during_wr: got %h want 1234", rd); end
    vecs++; if (prdata[0] !== 16'h1234) begin errs++; $display("FAIL hold_after_wr: got %h want 1234", prdata[0]); end
    xfer(0, 1'b0, 20'h10, 16'hFFFF, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'h0000) begin errs++; $display("FAIL hold_rd_new: got %h want 0000", rd); end
  endtask
  task automatic test_err_window;
    logic [15:0] rd;
    logic er;
    int wt;
    xfer(0, 1'b1, 20'h104, 16'hFFFF, 2'b11, rd, er, wt);
    vecs++; if (er !== 1'b1) begin errs++; $display("FAIL win_wr_err: got %b want 1", er); end
    xfer(0, 1'b0, 20'h104, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (er !== 1'b1) begin errs++; $display("FAIL win_rd_err: got %b want 1", er); end
    vecs++; if (rd !== 16'h0000) begin errs++; $display("FAIL win_rd_data: got %h want 0000", rd); end
    vecs++; if (err_cnt[0] !== 16'd2) begin errs++; $display("FAIL win_err_cnt: got %0d want 2", err_cnt[0]); end
    xfer(0, 1'b0, 20'h1FF, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (er !== 1'b1 || rd !== 16'h0000) begin errs++; $display("FAIL win_top: got err %b data %h want err 1 data 0000", er, rd); end
    xfer(0, 1'b0, 20'h200, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (er !== 1'b0 || rd !== 16'hABCD) begin errs++; $display("FAIL win_above: got err %b data %h want err 0 data abcd", er, rd); end
    xfer(0, 1'b0, 20'h0FE, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (er !== 1'b0 || rd !== 16'hABCD) begin errs++; $display("FAIL win_below: got err %b data %h want err 0 data abcd", er, rd); end
    vecs++; if (err_cnt[0] !== 16'd3) begin errs++; $display("FAIL win_err_cnt3: got %0d want 3", err_cnt[0]); end
    vecs++; if (xfer_cnt[0] !== 16'd16) begin errs++; $display("FAIL win_xfer_cnt: got %0d want 16", xfer_cnt[0]); end
  endtask
  task automatic test_proto;
    @(posedge clk); #1;
    sel_vec = 3'b001;
    penable = 1'b1;
    @(posedge clk); #1;
    vecs++; if (proto_err[0] !== 1'b1) begin errs++; $display("FAIL proto_idle_pulse: got %b want 1", proto_err[0]); end
    vecs++; if (pready[0] !== 1'b0) begin errs++; $display("FAIL proto_idle_pready: got %b want 0", pready[0]); end
    sel_vec = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
    vecs++; if (proto_err[0] !== 1'b0) begin errs++; $display("FAIL proto_idle_clear: got %b want 0", proto_err[0]); end
    vecs++; if (xfer_cnt[0] !== 16'd16) begin errs++; $display("FAIL proto_idle_cnt: got %0d want 16", xfer_cnt[0]); end
  endtask
  task automatic test_wait_fixed;
    logic [15:0] rd;
    logic er;
    int wt;
    xfer(1, 1'b0, 20'h20, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (wt != 3) begin errs++; $display("FAIL fix_rd_wait: got %0d want 3", wt); end
    vecs++; if (rd !== 16'hABCD || er !== 1'b0) begin errs++; $display("FAIL fix_rd: got data %h err %b want abcd 0", rd, er); end
    xfer(1, 1'b1, 20'h50, 16'h1357, 2'b11, rd, er, wt);
    vecs++; if (wt != 3) begin errs++; $display("FAIL fix_wr_wait: got %0d want 3", wt); end
    xfer(1, 1'b0, 20'h50, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'h1357) begin errs++; $display("FAIL fix_b2b_rd: got %h want 1357", rd); end
    xfer(1, 1'b0, 20'h200, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (er !== 1'b1 || rd !== 16'h0000) begin errs++; $display("FAIL fix_oor: got err %b data %h want 1 0000", er, rd); end
    vecs++; if (wt != 3) begin errs++; $display("FAIL fix_oor_wait: got %0d want 3", wt); end
    xfer(1, 1'b0, 20'h1FE, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (er !== 1'b0 || rd !== 16'hABCD) begin errs++; $display("FAIL fix_last_word: got err %b data %h want 0 abcd", er, rd); end
    vecs++; if (xfer_cnt[1] !== 16'd5) begin errs++; $display("FAIL fix_xfer_cnt: got %0d want 5", xfer_cnt[1]); end
    vecs++; if (err_cnt[1] !== 16'd1) begin errs++; $display("FAIL fix_err_cnt: got %0d want 1", err_cnt[1]); end
  endtask
  task automatic test_abort;
    logic [15:0] rd;
    logic er;
    int wt;
    sel_vec = 3'b010;
    paddr = 20'h40;
    pwrite = 1'b1;
    pwdata = 16'h1111;
    pstrb = 2'b11;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    sel_vec = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
    vecs++; if (proto_err[1] !== 1'b1) begin errs++; $display("FAIL abort_pulse: got %b want 1", proto_err[1]); end
    vecs++; if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0) begin errs++; $display("FAIL abort_resp: got pready %b pslverr %b want 0 0", pready[1], pslverr[1]); end
    @(posedge clk); #1;
    vecs++; if (proto_err[1] !== 1'b0) begin errs++; $display("FAIL abort_clear: got %b want 0", proto_err[1]); end
    xfer(1, 1'b0, 20'h40, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'hABCD) begin errs++; $display("FAIL abort_nocommit: got %h want abcd", rd); end
    vecs++; if (xfer_cnt[1] !== 16'd6) begin errs++; $display("FAIL abort_cnt: got %0d want 6", xfer_cnt[1]); end
  endtask
  task automatic test_random;
    logic [15:0] model [256];
    logic [15:0] rd, wd;
    logic [19:0] a;
    logic [1:0] s;
    logic er, w;
    int wt;
    bit saw_zero, saw_wait;
    saw_zero = 1'b0;
    saw_wait = 1'b0;
    foreach (model[i]) model[i] = 16'hABCD;
    for (int n = 0; n < 1000; n++) begin
      a = 20'($urandom_range(0, 511));
      w = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      s = 2'($urandom_range(0, 3));
      xfer(2, w, a, wd, s, rd, er, wt);
      if (wt == 0) saw_zero = 1'b1;
      else saw_wait = 1'b1;
      vecs++; if (wt > 3) begin errs++; $display("FAIL rnd_wait #%0d: got %0d want <=3", n, wt); end
      vecs++; if (er !== 1'b0) begin errs++; $display("FAIL rnd_err #%0d: got %b want 0", n, er); end
      if (w) begin
        if (s[0]) model[a[8:1]][7:0] = wd[7:0];
        if (s[1]) model[a[8:1]][15:8] = wd[15:8];
      end else begin
        vecs++; if (rd !== model[a[8:1]]) begin errs++; $display("FAIL rnd_data #%0d addr %h: got %h want %h", n, a, rd, model[a[8:1]]); end
      end
    end
    vecs++; if (!saw_zero || !saw_wait) begin errs++; $display("FAIL rnd_wait_mix: zero-wait seen %b nonzero-wait seen %b want 1 1", saw_zero, saw_wait); end
    vecs++; if (xfer_cnt[2] !== 16'd1000) begin errs++; $display("FAIL rnd_xfer_cnt: got %0d want 1000", xfer_cnt[2]); end
    vecs++; if (err_cnt[2] !== 16'd0) begin errs++; $display("FAIL rnd_err_cnt: got %0d want 0", err_cnt[2]); end
  endtask
  task automatic test_reset_mid;
    logic [15:0] rd;
    logic er;
    int wt;
    xfer(1, 1'b0, 20'h50, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'h1357) begin errs++; $display("FAIL rmid_pre_rd: got %h want 1357", rd); end
    sel_vec = 3'b010;
    paddr = 20'h40;
    pwrite = 1'b1;
    pwdata = 16'h2222;
    pstrb = 2'b11;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    vecs++; if (prdata[1] !== 16'hABCD) begin errs++; $display("FAIL rmid_prdata: got %h want abcd", prdata[1]); end
    vecs++; if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || proto_err[1] !== 1'b0) begin errs++; $display("FAIL rmid_flags: got %b%b%b want 000", pready[1], pslverr[1], proto_err[1]); end
    vecs++; if (xfer_cnt[1] !== 16'd0 || err_cnt[1] !== 16'd0) begin errs++; $display("FAIL rmid_cnts: got %0d %0d want 0 0", xfer_cnt[1], err_cnt[1]); end
    vecs++; if (xfer_cnt[0] !== 16'd0) begin errs++; $display("FAIL rmid_cnt_u0: got %0d want 0", xfer_cnt[0]); end
    sel_vec = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 20'h40, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'hABCD) begin errs++; $display("FAIL rmid_nocommit: got %h want abcd", rd); end
    xfer(1, 1'b0, 20'h50, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'hABCD) begin errs++; $display("FAIL rmid_reinit_u1: got %h want abcd", rd); end
    xfer(0, 1'b0, 20'h10, 16'h0000, 2'b11, rd, er, wt);
    vecs++; if (rd !== 16'hABCD) begin errs++; $display("FAIL rmid_reinit_u0: got %h want abcd", rd); end
    vecs++; if (xfer_cnt[1] !== 16'd2) begin errs++; $display("FAIL rmid_cnt_after: got %0d want 2", xfer_cnt[1]); end
  endtask
  initial begin
    test_reset;
    test_mode0;
    test_strobe;
    test_hold;
    test_err_window;
    test_proto;
    test_wait_fixed;
    test_abort;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dv_apb_mem_slave.md
# dv_apb_mem_slave

Parametrised APB completer memory model for the DV library, instantiated in block and top-level benches as the target of an APB requester under test. Unlike a stub responder, it holds real storage with byte-strobed writes and read-back. It generates wait states in a fixed or pseudo-random mode, injects `pslverr` on a configurable address window, and keeps transfer and error counters for scoreboard checks.

## Interface
- `DATA_W`, 16, data width in bits; multiple of 8.
- `ADDR_W`, 20, `paddr` width.
- `DEPTH`, 256, number of `DATA_W` words; power of two, ≤ 1024.
- `SEL_W`, 2, `psel` width.
- `SEL_IDX`, 0, `psel` bit this instance responds to.
- `WAIT_MODE`, 0: 0 = no waits, 1 = fixed `WAIT_CYC`, 2 = LFSR-random.
- `WAIT_CYC`, 2, 4-bit value; fixed wait count (mode 1) or mask on LFSR bits (mode 2).
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.
- `ERR_BASE`, 0, first byte address of the error window.
- `ERR_LIMIT`, 0, last byte address of the error window; `ERR_LIMIT < ERR_BASE` disables the window.
- `RESET_DATA`, 16'hABCD, reset value of every memory word and of `prdata` (truncated or zero-extended to `DATA_W`).

Ports:
- `clk` input 1, the single clock.
- `reset_n` input 1, asynchronous active-low reset.
- `penable` input 1, APB enable.
- `psel` input `SEL_W`, APB selects; only bit `SEL_IDX` is used.
- `paddr` input `ADDR_W`, byte address.
- `pwdata` input `DATA_W`, write data.
- `pwrite` input 1, 1 = write.
- `pstrb` input `DATA_W/8`, write byte strobes.
- `prdata` output `DATA_W`, read data; valid while `pready`=1.
- `pready` output 1, transfer completes at the edge where `pready`=`penable`=1.
- `pslverr` output 1, error flag; only ever high together with `pready`.
- `proto_err` output 1, one-cycle pulse on a protocol violation.
- `xfer_cnt` output 16, completed transfers.
- `err_cnt` output 16, completed transfers that had `pslverr`=1.

## Operation
- Reset values: `prdata`=`RESET_DATA`, `pready`=0, `pslverr`=0, `proto_err`=0, both counters 0, all memory words=`RESET_DATA`, LFSR=`LFSR_SEED`, state IDLE.
- `sel` is `psel[SEL_IDX]`.
- Word index is `paddr >> log2(DATA_W/8)`.
- Error condition: index ≥ `DEPTH`, or `paddr` within [`ERR_BASE`,`ERR_LIMIT`].
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle regardless of traffic.
- Wait count W: mode 0 → W=0; mode 1 → W=`WAIT_CYC`; mode 2 → W=`lfsr[3:0] & WAIT_CYC`. W is sampled at the setup edge.
- FSM states:
  - IDLE, on `sel`=1 and `penable`=0 → ACCESS. Loads counter with W. `pready` is registered to (W==0). On that edge `prdata` loads the addressed word for a read, or 0 for an error read. `pslverr` loads the error condition when W==0.
  - IDLE, on `penable`=1 → `proto_err` pulse, no access.
  - ACCESS, while counter ≠ 0: decrement. On the edge where the counter goes 1→0, raise `pready` and load `prdata`/`pslverr` as above.
  - ACCESS, completion edge (`pready`=`penable`=`sel`=1): the write commits on this edge, but only lanes with `pstrb[i]`=1, and not when in error. `xfer_cnt`+1; `err_cnt`+1 if `pslverr`. `pready` and `pslverr` go to 0. Next state is IDLE.
  - ACCESS, `sel` dropped before completion → abort: no commit, no count, `proto_err` pulse, `pready`/`pslverr` to 0, next state IDLE.
- Write with `pstrb`=0: completes OKAY and leaves memory unchanged. `pstrb` is ignored on reads.
- Counters wrap 16'hFFFF→0.
- Back-to-back transfers: a new setup in the cycle after completion is accepted; there is no mandatory idle cycle.
- Address, data and `pwrite` are sampled at the setup edge. Changes to them during ACCESS are ignored.

## Timing
- Setup phase in cycle T, `penable` high from T+1: `pready` is high in cycle T+1+W. The transfer takes exactly W+2 cycles including setup.
- Read data and `pslverr` are valid in the same cycle `pready` is high. `prdata` holds its value afterwards until the next read completes.
- Written data is readable by a transfer whose setup is in the cycle immediately after the write completes.
- `reset_n` low mid-transfer: all outputs go to their reset values immediately (asynchronous), the transfer is not committed, and memory is re-initialised.

## Test plan
- Mode 0: write 16'h1234 to 0x10 with `pstrb`=2'b11, then read 0x10 → `pready` in the first access cycle, `prdata`=16'h1234, `pslverr`=0, `xfer_cnt`=2.
- Mode 1, `WAIT_CYC`=3: read 0x20 after reset → `pready` high at T+4, `prdata`=16'hABCD.
- `pstrb`=2'b01 write 16'h55AA to 0x30, then read → `prdata`=16'hABAA. Then a `pstrb`=0 write → value unchanged.
- `ERR_BASE`=0x100, `ERR_LIMIT`=0x1FF: write 16'hFFFF to 0x104, then read it → `pslverr`=1 on both, `prdata`=0, `err_cnt`=2. Read 0x200 → OKAY, 16'hABCD.
- Mode 2: 1000 random transfers against a scoreboard → data matches, every wait ≤ `WAIT_CYC`, `xfer_cnt`=1000.
- Drop `psel` during a wait, and separately assert `reset_n` low during a wait → no commit, `proto_err` pulses (abort case), and all outputs return to their reset values.
